// File: rtl/paralelo_serie_param.sv
// paralelo_serie_param: parameterised parallel-to-serial converter on one
// bit-rate clock. A free-running bit counter frames the stream. A word is
// taken through ready/valid on the load edge (cnt == FRAME-1). Without a
// valid word, IDLE_WORD (COM) is sent instead.
// Optional feature macro: PS_PARITY_EN adds a trailing even-parity slot,
// giving FRAME = WIDTH+1.
module paralelo_serie_param #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(8'hBC),
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic             clk_8f,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_inP,
  output logic             ready_out,
  output logic             data_outS,
  output logic             word_start,
  output logic             idle_out
);

`ifdef PS_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int               CNT_W    = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(FRAME - 1);
  localparam logic [CNT_W-1:0] PAR_SLOT = CNT_W'(WIDTH - 1);

  // Even parity of a word (XOR of all bits).
  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             dout_q, dout_d;
  logic             idle_q, idle_d;
  logic             ws_q, ws_d;
  logic             parity_q, parity_d;
  logic             load_s;
  logic [WIDTH-1:0] word_s;

  assign load_s = (cnt_q == LAST);

  // Word chosen on the load edge: offered data when valid, else COM.
  assign word_s = valid_in ? data_inP : IDLE_WORD;

  // Next-state logic: load a new frame on the load edge, otherwise shift.
  always_comb begin
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    dout_d   = dout_q;
    idle_d   = idle_q;
    ws_d     = 1'b0;
    parity_d = parity_q;
    if (load_s) begin
      cnt_d    = {CNT_W{1'b0}};
      ws_d     = 1'b1;
      idle_d   = ~valid_in;
      parity_d = even_parity(word_s);
      if (MSB_FIRST) begin
        dout_d  = word_s[WIDTH-1];
        shreg_d = word_s << 1;
      end else begin
        dout_d  = word_s[0];
        shreg_d = word_s >> 1;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
`ifdef PS_PARITY_EN
      if (cnt_q == PAR_SLOT) begin
        // All data bits have been sent; the extra slot carries parity.
        dout_d = parity_q;
      end else if (MSB_FIRST) begin
        dout_d  = shreg_q[WIDTH-1];
        shreg_d = shreg_q << 1;
      end else begin
        dout_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
`else
      if (MSB_FIRST) begin
        dout_d  = shreg_q[WIDTH-1];
        shreg_d = shreg_q << 1;
      end else begin
        dout_d  = shreg_q[0];
        shreg_d = shreg_q >> 1;
      end
`endif
    end
  end

  // State registers. Reset parks the counter on the load slot, so the
  // first edge after release starts a full frame.
  always_ff @(posedge clk_8f or negedge reset) begin
    if (!reset) begin
      cnt_q    <= LAST;
      shreg_q  <= {WIDTH{1'b0}};
      dout_q   <= 1'b0;
      idle_q   <= 1'b1;
      ws_q     <= 1'b0;
      parity_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      dout_q   <= dout_d;
      idle_q   <= idle_d;
      ws_q     <= ws_d;
      parity_q <= parity_d;
    end
  end

`ifndef PS_PARITY_EN
  // The parity slot is not used in this build.
  logic unused_s;
  assign unused_s = ^{PAR_SLOT, parity_q};
`endif

  assign ready_out  = reset & load_s;
  assign data_outS  = dout_q;
  assign word_start = ws_q;
  assign idle_out   = idle_q;

endmodule

// File: tb/tb_paralelo_serie_param.sv
// Self-checking bench for paralelo_serie_param: an MSB-first and an
// LSB-first instance share their inputs. Expected frames come from a
// vector table and are queued when the word is offered, then popped one
// bit per cycle and compared.
module tb_paralelo_serie_param;

`ifdef PS_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk_8f = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [7:0] data_inP;
  logic       ready_m, dout_m, ws_m, idle_m;
  logic       ready_l, dout_l, ws_l, idle_l;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    logic       valid;
    logic [7:0] data;
    logic [7:0] msb_pat;   // transmit order, leftmost bit first
    logic [7:0] lsb_pat;   // transmit order, leftmost bit first
    logic       idle;
    logic       par;
  } vec_t;

  typedef struct {
    logic msb_bit;
    logic lsb_bit;
    logic ws;
    logic idle;
    logic rdy;
  } exp_t;

  vec_t vecs[9];
  exp_t q[$];

  always #5 clk_8f = ~clk_8f;

  paralelo_serie_param #(.WIDTH(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b1)) dut_msb (
    .clk_8f(clk_8f), .reset(reset), .valid_in(valid_in), .data_inP(data_inP),
    .ready_out(ready_m), .data_outS(dout_m), .word_start(ws_m), .idle_out(idle_m)
  );

  paralelo_serie_param #(.WIDTH(8), .IDLE_WORD(8'hBC), .MSB_FIRST(1'b0)) dut_lsb (
    .clk_8f(clk_8f), .reset(reset), .valid_in(valid_in), .data_inP(data_inP),
    .ready_out(ready_l), .data_outS(dout_l), .word_start(ws_l), .idle_out(idle_l)
  );

  task automatic chk(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Queue the expected frame for one vector.
  task automatic push_frame(input vec_t v);
    exp_t e;
    for (int i = 0; i < FRAME; i++) begin
      e.msb_bit = (i < 8) ? v.msb_pat[7-i] : v.par;
      e.lsb_bit = (i < 8) ? v.lsb_pat[7-i] : v.par;
      e.ws      = (i == 0);
      e.idle    = v.idle;
      e.rdy     = (i == FRAME - 1);
      q.push_back(e);
    end
  endtask

  // Pop one expected bit and compare both instances (call just after negedge).
  task automatic check_cycle();
    exp_t e;
    if (q.size() == 0) begin
      chk("queue_empty", 1'b1, 1'b0);
    end else begin
      e = q.pop_front();
      chk("data_msb",   dout_m,  e.msb_bit);
      chk("data_lsb",   dout_l,  e.lsb_bit);
      chk("word_start", ws_m,    e.ws);
      chk("idle_out",   idle_m,  e.idle);
      chk("ready_out",  ready_m, e.rdy);
      chk("ready_lsb",  ready_l, e.rdy);
    end
  endtask

  // Offer a word in the load slot; scramble inputs after acceptance;
  // check `nbits` cycles of output.
  task automatic run_frame(input vec_t v, input int nbits);
    valid_in = v.valid;
    data_inP = v.data;
    #1;
    chk("ready_at_load", ready_m, 1'b1);
    push_frame(v);
    @(posedge clk_8f);
    #1;
    valid_in = 1'($urandom);
    data_inP = 8'($urandom);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_8f);
      check_cycle();
    end
  endtask

  initial begin
    vecs[0] = '{1'b0, 8'h3C, 8'b10111100, 8'b00111101, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 8'hAA, 8'b10111100, 8'b00111101, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 8'hAA, 8'b10101010, 8'b01010101, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'hBB, 8'b10111011, 8'b11011101, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'hAC, 8'b10101100, 8'b00110101, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'hAA, 8'b10101010, 8'b01010101, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'hAC, 8'b10111100, 8'b00111101, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'hAC, 8'b10101100, 8'b00110101, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 8'hAB, 8'b10101011, 8'b11010101, 1'b0, 1'b1};

    // Reset held for three cycles; check reset values.
    reset    = 1'b0;
    valid_in = 1'b0;
    data_inP = 8'h00;
    repeat (3) @(negedge clk_8f);
    chk("rst_data",  dout_m,  1'b0);
    chk("rst_ws",    ws_m,    1'b0);
    chk("rst_idle",  idle_m,  1'b1);
    chk("rst_ready", ready_m, 1'b0);
    reset = 1'b1;

    // Table: idle stream, back-to-back data, idle insertion, parity words.
    for (int k = 0; k < 9; k++) run_frame(vecs[k], FRAME);

    // Reset in the middle of a frame (while bit 3 is on the line).
    run_frame(vecs[2], 4);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_data",  dout_m,  1'b0);
    chk("midrst_ready", ready_m, 1'b0);
    chk("midrst_ws",    ws_m,    1'b0);
    chk("midrst_idle",  idle_m,  1'b1);
    q.delete();
    @(posedge clk_8f);
    #1;
    chk("rst_hold_data", dout_m, 1'b0);
    @(negedge clk_8f);
    reset = 1'b1;
    run_frame(vecs[3], FRAME);
    run_frame(vecs[0], FRAME);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
